// File: rtl/mem_burst_reader.sv
// mem_burst_reader: streams a burst of consecutive memory words onto a valid/ready interface.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   start               burst request, sampled only while idle
//   base_addr, length   first word address and word count, captured with start
//   busy, done          burst in progress / one-cycle completion pulse
//   mem_address         registered read address to the memory port
//   mem_wren            write enable to the memory port, tied low
//   mem_q               memory read data, valid one cycle after mem_address
//   out_data            stream data (head of the skid FIFO)
//   out_valid           stream valid (skid FIFO non-empty)
//   out_ready           stream ready from the consumer
//   out_last            marks the final word of the burst
module mem_burst_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int LEN_W = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_address,
    output logic             mem_wren,
    input  logic [WIDTH-1:0] mem_q,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_nx;
    logic             v1, v2;
    logic [LEN_W-1:0] rem_issue, rem_xfer;
    logic [WIDTH-1:0] fifo [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       count;
    logic [3:0]       inflight;
    logic             launch, issue, push, pop;
    logic [AW-1:0]    next_addr;

    // The start itself presents base_addr, so the first read needs no issue slot.
    assign launch    = state == IDLE && start && length != '0;
    // Reads in the memory pipeline count against FIFO space; no pop look-ahead.
    assign inflight  = 4'(count) + 4'(v1) + 4'(v2);
    assign issue     = state == RUN && rem_issue != '0 && inflight < 4'd4;
    assign push      = v2;
    assign pop       = out_valid && out_ready;
    // Explicit wrap so non-power-of-two depths also return to address 0.
    assign next_addr = mem_address == AW'(DEPTH - 1) ? '0 : mem_address + AW'(1);

    assign mem_wren  = 1'b0;
    assign out_valid = count != 3'd0;
    assign out_data  = out_valid ? fifo[rd_ptr] : '0;
    assign out_last  = out_valid && rem_xfer == LEN_W'(1);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = length != '0 ? RUN : FINISH;
            RUN:     if (pop && rem_xfer == LEN_W'(1)) state_nx = FINISH;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state == RUN;
        done = state == FINISH;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            mem_address <= '0;
            rem_issue   <= '0;
            rem_xfer    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            v1 <= launch || issue;
            v2 <= v1;
            if (launch) begin
                mem_address <= base_addr;
                rem_issue   <= length - LEN_W'(1);
            end else if (issue) begin
                mem_address <= next_addr;
                rem_issue   <= rem_issue - LEN_W'(1);
            end
            rem_xfer <= launch ? length : pop ? rem_xfer - LEN_W'(1) : rem_xfer;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo[wr_ptr] <= mem_q;
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && count == 3'd4));

endmodule
